// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - boot loader: framed byte stream into 256x16 RAM, holds CPU in reset until a checksummed frame lands
module ram_loader #(
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        ram_w_en,
  output logic [7:0]  ram_w_addr,
  output logic [15:0] ram_w_data,
  output logic        cpu_rst_n,
  output logic [7:0]  start_pc,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_HI, S_LO, S_CSUM, S_RUN
  } state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_ptr, r_addr, r_sum, r_hi;
  logic [8:0]  r_cnt;
  logic        r_w_en, r_cpu_rst_n, r_done, r_err;
  logic [7:0]  r_w_addr, r_start_pc;
  logic [15:0] r_w_data;
  logic        w_accept;

  assign in_ready   = (r_state != S_RUN);
  assign w_accept   = in_valid && in_ready;
  assign ram_w_en   = r_w_en;
  assign ram_w_addr = r_w_addr;
  assign ram_w_data = r_w_data;
  assign cpu_rst_n  = r_cpu_rst_n;
  assign start_pc   = r_start_pc;
  assign done       = r_done;
  assign err        = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_accept) begin
      case (r_state)
        S_IDLE:  if (in_byte == HEADER) w_next = S_ADDR;
        S_ADDR:  w_next = S_LEN;
        S_LEN:   w_next = S_HI;
        S_HI:    w_next = S_LO;
        S_LO:    w_next = (r_cnt == 9'd1) ? S_CSUM : S_HI;
        S_CSUM:  w_next = (in_byte == r_sum) ? S_RUN : S_IDLE;
        default: w_next = r_state;
      endcase
    end
  end

  // Datapath; the write strobe is a single-cycle pulse cleared every cycle by default.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= 8'd0;
      r_addr      <= 8'd0;
      r_sum       <= 8'd0;
      r_hi        <= 8'd0;
      r_cnt       <= 9'd0;
      r_w_en      <= 1'b0;
      r_w_addr    <= 8'd0;
      r_w_data    <= 16'd0;
      r_cpu_rst_n <= 1'b0;
      r_start_pc  <= 8'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_w_en <= 1'b0;
      if (w_accept) begin
        case (r_state)
          S_IDLE: if (in_byte == HEADER) r_err <= 1'b0;
          S_ADDR: begin
            r_ptr  <= in_byte;
            r_addr <= in_byte;
            r_sum  <= in_byte;
          end
          S_LEN: begin
            r_cnt <= (in_byte == 8'd0) ? 9'd256 : {1'b0, in_byte};
            r_sum <= r_sum + in_byte;
          end
          S_HI: begin
            r_hi  <= in_byte;
            r_sum <= r_sum + in_byte;
          end
          S_LO: begin
            r_w_en   <= 1'b1;
            r_w_addr <= r_ptr;
            r_w_data <= {r_hi, in_byte};
            r_ptr    <= r_ptr + 8'd1;
            r_cnt    <= r_cnt - 9'd1;
            r_sum    <= r_sum + in_byte;
          end
          S_CSUM: begin
            if (in_byte == r_sum) begin
              r_start_pc  <= r_addr;
              r_done      <= 1'b1;
              r_cpu_rst_n <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/ram_loader.md
# ram_loader

Boot-time program loader that sits upstream of the CPU and its 256×16 RAM. It accepts a framed byte stream over a valid/ready interface and assembles 16-bit words. It writes those words into RAM through the RAM write port, and holds the CPU in reset until a complete frame with a correct checksum has been written. It then releases the CPU and presents the frame's load address as `start_pc`.

## Interface
Parameters:
- `HEADER`, 8'hA5: frame start byte.

Ports:
- `clk` input 1: single clock, all logic on posedge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_byte` is valid this cycle.
- `in_byte` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `ram_w_en` output 1: one-cycle RAM write strobe.
- `ram_w_addr` output 8: RAM write address.
- `ram_w_data` output 16: RAM write data.
- `cpu_rst_n` output 1: active-low CPU reset, low while loading.
- `start_pc` output 8: CPU start address, valid when `done`=1.
- `done` output 1: load completed successfully.
- `err` output 1: last frame failed its checksum.

## Operation
- Accept a byte when `in_valid`=1 and `in_ready`=1 at posedge (an "accept").
- Frame format: `HEADER`, ADDR, LEN, then 2×N data bytes with the high byte first, then CSUM.
  - N = LEN, except LEN=0 means N=256.
- CSUM = 8-bit sum mod 256 of ADDR, LEN and all data bytes. `HEADER` is excluded from the sum.
- States: IDLE → ADDR → LEN → HI ⇄ LO → CSUM → RUN.
  - IDLE: accept any byte. A byte equal to `HEADER` moves to ADDR and clears `err`. Any other byte is discarded and the state stays IDLE.
  - ADDR: latch the write pointer and `start_pc` candidate; start the running sum with this byte. Go to LEN.
  - LEN: latch the remaining-word count (9 bits, 0→256); add the byte to the sum. Go to HI.
  - HI: latch the high byte; add it to the sum. Go to LO.
  - LO: form the word {hi, byte}; add the byte to the sum; issue the RAM write; increment the pointer mod 256; decrement the count. If the count reaches 0, go to CSUM; otherwise go to HI.
  - CSUM: if the byte equals the sum, set `start_pc` to ADDR, set `done`=1, set `cpu_rst_n`=1 and go to RUN. Otherwise set `err`=1 and go to IDLE.
  - RUN: terminal until `rst`. `in_ready`=0; the stream is ignored.
- `in_ready` = 1 in every state except RUN. It is combinational from the state.
- Address pointer wraps from 8'hFF to 8'h00. There is no overflow error.
- On a checksum failure, RAM words already written are not rolled back. `cpu_rst_n` stays 0.
- `err` is sticky until the next accepted `HEADER` byte or `rst`.
- `done` and `err` are never both 1.

## Timing
- Reset values (asynchronous, immediate on `rst`=1):
  - state IDLE.
  - `ram_w_en`=0, `ram_w_addr`=0, `ram_w_data`=0.
  - `cpu_rst_n`=0, `start_pc`=0, `done`=0, `err`=0.
- `in_ready`=1 from the first cycle after `rst` deasserts.
- All outputs except `in_ready` are registered.
- RAM write: `ram_w_en`=1 for exactly one cycle, in the cycle after the LO byte is accepted. `ram_w_addr` and `ram_w_data` are valid in that same cycle. Outside write cycles, `ram_w_addr` and `ram_w_data` hold their last values.
- Back-to-back accepts (one per cycle) are supported in all states with no stall. Gaps in `in_valid` are tolerated in any state, indefinitely.
- Last word's write strobe and the CSUM accept may occur in the same cycle. The write completes before `cpu_rst_n` rises.
- `done`, `cpu_rst_n` and `start_pc` update in the cycle after the CSUM accept. `err` also updates in the cycle after the CSUM accept.
- `rst` mid-frame aborts immediately. No further write is issued, and the partial word is discarded.

## Test plan
- Stream A5 10 02 12 34 AB CD D0, back-to-back → writes (0x10, 0x1234) then (0x11, 0xABCD), one `ram_w_en` cycle each. Then `done`=1, `cpu_rst_n`=1, `start_pc`=0x10, `in_ready`=0.
- Stream A5 FF 02 00 01 00 02 04 → writes (0xFF, 0x0001) then (0x00, 0x0002), showing address wrap. Then `done`=1, `start_pc`=0xFF.
- First frame above with CSUM D1 → both writes occur, then `err`=1, `done`=0, `cpu_rst_n`=0, state IDLE. Resend it with D0 → `err` clears on the A5 accept, and the load completes.
- Bytes 00 FF 5A, then the first frame with `in_valid` toggling 1/0 every cycle → leading bytes are discarded with no writes, and the result is identical to the first scenario.
- LEN=00 frame (256 words of 0x0000, ADDR 0x00, CSUM 0x00) → exactly 256 writes to addresses 0x00..0xFF, then `done`=1.
- Assert `rst` one cycle after the HI byte 0x12 is accepted → all outputs return to reset values, and no write of 0x12xx occurs. A following full first frame loads correctly.
